rd_ptr_ctrl: RTL and testbench

Parametrised read-side pointer and status controller for the asynchronous FIFO. It runs in the read clock domain and keeps the binary and Gray read pointers. From the write pointer, already synchronised into the read domain by two flops, it derives registered empty, almost-empty and occupancy outputs. Its optional sticky underflow flag catches reads issued while the FIFO is empty.

---
 rtl/rd_ptr_ctrl.sv | 101 ++++++++++
 tb/tb_rd_ptr_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rd_ptr_ctrl.sv
// rd_ptr_ctrl: read-side pointer and status controller for an asynchronous FIFO.
// Keeps the binary and Gray read pointers. Derives registered empty,
// almost-empty and occupancy from the write pointer, which arrives already
// synchronised into the read clock domain.
// Optional feature: define RD_PTR_UNDERFLOW_EN to add the sticky RUNDERFLOW
// flag. It records reads that were issued while the FIFO was empty.
module rd_ptr_ctrl #(
    parameter int ADDR_SIZE     = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 RCLK,
    input  logic                 RRST,
    input  logic                 RINC,
    input  logic [ADDR_SIZE:0]   RQ2_WPTR,
    output logic [ADDR_SIZE:0]   RPTR,
    output logic [ADDR_SIZE-1:0] RADDR,
    output logic                 REMPTY,
    output logic                 RAEMPTY,
`ifdef RD_PTR_UNDERFLOW_EN
    output logic                 RUNDERFLOW,
`endif
    output logic [ADDR_SIZE:0]   RCOUNT
);

    localparam int PW = ADDR_SIZE + 1;
    // The threshold may equal the full depth, so it needs the full pointer width.
    localparam logic [ADDR_SIZE:0] THRESH = PW'(AEMPTY_THRESH);

    logic [ADDR_SIZE:0] rbin_q, rbin_d;
    logic [ADDR_SIZE:0] rptr_q, rptr_d;
    logic [ADDR_SIZE:0] rcount_q, rcount_d;
    logic               rempty_q, rempty_d;
    logic               raempty_q, raempty_d;
    logic [ADDR_SIZE:0] wbin;
    logic               rd_en;

    // Decode the synchronised Gray write pointer to binary.
    // Each binary bit is the XOR of all Gray bits at or above its position.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            wbin[i] = ^(RQ2_WPTR >> i);
        end
    end

    // Next pointer and next status. A read against an empty FIFO is dropped.
    always_comb begin
        rd_en     = RINC & ~rempty_q;
        rbin_d    = rbin_q + PW'(rd_en);
        rptr_d    = (rbin_d >> 1) ^ rbin_d;
        rcount_d  = wbin - rbin_d;
        rempty_d  = (rptr_d == RQ2_WPTR);
        raempty_d = (rcount_d <= THRESH);
    end

    // Pointer and status registers. Reset comes up empty with the pointer at zero.
    always_ff @(posedge RCLK) begin
        if (RRST) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rcount_q  <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            rcount_q  <= rcount_d;
            rempty_q  <= rempty_d;
            raempty_q <= raempty_d;
        end
    end

    assign RPTR    = rptr_q;
    assign RADDR   = rbin_q[ADDR_SIZE-1:0];
    assign REMPTY  = rempty_q;
    assign RAEMPTY = raempty_q;
    assign RCOUNT  = rcount_q;

`ifdef RD_PTR_UNDERFLOW_EN
    logic runderflow_q, runderflow_d;

    // The underflow flag is sticky. Only reset clears it.
    always_comb begin
        runderflow_d = runderflow_q | (RINC & rempty_q);
    end

    // Underflow flag register.
    always_ff @(posedge RCLK) begin
        if (RRST) begin
            runderflow_q <= 1'b0;
        end else begin
            runderflow_q <= runderflow_d;
        end
    end

    assign RUNDERFLOW = runderflow_q;
`else
    // Without the flag, a read against an empty FIFO is dropped silently.
`endif

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Testbench for rd_ptr_ctrl with ADDR_SIZE=4 and AEMPTY_THRESH=2.
module tb_rd_ptr_ctrl;

    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int THRESH = 2;

    logic          clk;
    logic          rrst;
    logic          rinc;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW-1:0] raddr;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   rcount;
`ifdef RD_PTR_UNDERFLOW_EN
    logic          runderflow;
`endif

    int nerr    = 0;
    int nchecks = 0;

    rd_ptr_ctrl #(.ADDR_SIZE(AW), .AEMPTY_THRESH(THRESH)) dut (
        .RCLK      (clk),
        .RRST      (rrst),
        .RINC      (rinc),
        .RQ2_WPTR  (wptr),
        .RPTR      (rptr),
        .RADDR     (raddr),
        .REMPTY    (rempty),
        .RAEMPTY   (raempty),
`ifdef RD_PTR_UNDERFLOW_EN
        .RUNDERFLOW(runderflow),
`endif
        .RCOUNT    (rcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic rinc;
        int   wbin;
        int   cnt;
        logic e;
        logic ae;
        int   addr;
        int   gptr;
        logic uf;
    } vec_t;

    vec_t tbl[16];

    function automatic int gray(int b);
        int m;
        m = b & (2 * DEPTH - 1);
        return m ^ (m >> 1);
    endfunction

    task automatic chk(string name, int act, int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference state for the random phase. It is kept as unbounded word totals.
    int  rd_tot, wr_tot;
    int  m_cnt;
    bit  m_empty, m_aempty, m_uf;

    task automatic model_cycle(bit rst, bit rd);
        if (rst) begin
            rd_tot   = 0;
            m_cnt    = 0;
            m_empty  = 1;
            m_aempty = 1;
            m_uf     = 0;
        end else begin
            if (rd && m_empty) m_uf = 1;
            if (rd && !m_empty) rd_tot++;
            m_cnt    = wr_tot - rd_tot;
            m_empty  = (m_cnt == 0);
            m_aempty = (m_cnt <= THRESH);
        end
    endtask

    initial begin
        int wraps, toggles, prev_addr, prev_msb;
        int wr_bias, rd_bias;
        bit r_rst, r_rd;

        rrst = 1'b1;
        rinc = 1'b0;
        wptr = '0;

        // Fill, drain, blocked reads, simultaneous events, reset mid-stream, full.
        tbl[0]  = '{1'b1, 1'b0,  0,  0, 1'b1, 1'b1, 0, 0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0,  5,  5, 1'b0, 1'b0, 0, 0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1,  5,  4, 1'b0, 1'b0, 1, 1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1,  5,  3, 1'b0, 1'b0, 2, 3, 1'b0};
        tbl[4]  = '{1'b0, 1'b1,  5,  2, 1'b0, 1'b1, 3, 2, 1'b0};
        tbl[5]  = '{1'b0, 1'b1,  5,  1, 1'b0, 1'b1, 4, 6, 1'b0};
        tbl[6]  = '{1'b0, 1'b1,  5,  0, 1'b1, 1'b1, 5, 7, 1'b0};
        tbl[7]  = '{1'b0, 1'b1,  5,  0, 1'b1, 1'b1, 5, 7, 1'b1};
        tbl[8]  = '{1'b0, 1'b1,  5,  0, 1'b1, 1'b1, 5, 7, 1'b1};
        tbl[9]  = '{1'b0, 1'b1,  5,  0, 1'b1, 1'b1, 5, 7, 1'b1};
        tbl[10] = '{1'b0, 1'b0,  8,  3, 1'b0, 1'b0, 5, 7, 1'b1};
        tbl[11] = '{1'b0, 1'b1,  9,  3, 1'b0, 1'b0, 6, 5, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 10,  3, 1'b0, 1'b0, 7, 4, 1'b1};
        tbl[13] = '{1'b1, 1'b1,  0,  0, 1'b1, 1'b1, 0, 0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 16, 16, 1'b0, 1'b0, 0, 0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 16, 15, 1'b0, 1'b0, 1, 1, 1'b0};

        for (int i = 0; i < 16; i++) begin
            rrst = tbl[i].rst;
            rinc = tbl[i].rinc;
            wptr = 5'(gray(tbl[i].wbin));
            step();
            chk($sformatf("tbl%0d RCOUNT", i), int'(rcount), tbl[i].cnt);
            chk($sformatf("tbl%0d REMPTY", i), int'(rempty), int'(tbl[i].e));
            chk($sformatf("tbl%0d RAEMPTY", i), int'(raempty), int'(tbl[i].ae));
            chk($sformatf("tbl%0d RADDR", i), int'(raddr), tbl[i].addr);
            chk($sformatf("tbl%0d RPTR", i), int'(rptr), tbl[i].gptr);
`ifdef RD_PTR_UNDERFLOW_EN
            chk($sformatf("tbl%0d RUNDERFLOW", i), int'(runderflow), int'(tbl[i].uf));
`endif
        end

        // Wrap: hold three words in flight while reading and writing every cycle.
        rrst = 1'b1; rinc = 1'b0; wptr = '0;
        step();
        rrst = 1'b0; wptr = 5'(gray(3));
        step();
        chk("wrap start RCOUNT", int'(rcount), 3);
        wraps = 0; toggles = 0; prev_addr = int'(raddr); prev_msb = int'(rptr[AW]);
        for (int k = 1; k <= 40; k++) begin
            rinc = 1'b1;
            wptr = 5'(gray(3 + k));
            step();
            chk($sformatf("wrap%0d RCOUNT", k), int'(rcount), 3);
            chk($sformatf("wrap%0d REMPTY", k), int'(rempty), 0);
            chk($sformatf("wrap%0d RADDR", k), int'(raddr), k % DEPTH);
            chk($sformatf("wrap%0d RPTR", k), int'(rptr), gray(k));
            if (prev_addr == DEPTH - 1 && int'(raddr) == 0) wraps++;
            if (int'(rptr[AW]) != prev_msb) toggles++;
            prev_addr = int'(raddr);
            prev_msb  = int'(rptr[AW]);
        end
        chk("wrap RADDR wraps", wraps, 2);
        chk("wrap RPTR msb toggles", toggles, 2);

        // Random traffic compared against the occupancy model.
        wr_tot = 0; rd_tot = 0;
        wr_bias = 50; rd_bias = 50;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) begin
                wr_bias = 20 + 30 * $urandom_range(0, 2);
                rd_bias = 20 + 30 * $urandom_range(0, 2);
            end
            r_rst = (c == 0) || ($urandom_range(0, 63) == 0);
            r_rd  = ($urandom_range(0, 99) < rd_bias);
            if (r_rst) wr_tot = 0;
            else if ((wr_tot - rd_tot) < DEPTH && $urandom_range(0, 99) < wr_bias) wr_tot++;
            rrst = r_rst;
            rinc = r_rd;
            wptr = 5'(gray(wr_tot));
            model_cycle(r_rst, r_rd);
            step();
            chk("rnd RCOUNT", int'(rcount), m_cnt);
            chk("rnd REMPTY", int'(rempty), int'(m_empty));
            chk("rnd RAEMPTY", int'(raempty), int'(m_aempty));
            chk("rnd RADDR", int'(raddr), rd_tot % DEPTH);
            chk("rnd RPTR", int'(rptr), gray(rd_tot));
`ifdef RD_PTR_UNDERFLOW_EN
            chk("rnd RUNDERFLOW", int'(runderflow), int'(m_uf));
`endif
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
